// File: rtl/bpe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : bpe_stage_buf
// Description : Single-stage butterfly operand buffer for SDF FFT/NTT kernels.
//               Stores one full frame of N = 2^pLOG_N words plus N/2 twiddle
//               constants. The twiddles arrive on the same stream port and are
//               selected by in_sw. After the last data beat, the block streams
//               butterfly operand pairs (X[ia], X[ib], twiddle[tw_idx]) for
//               the stage index latched on that last beat.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               in_sw          - beat mode: 00 data, 01 twiddle, 1x reserved
//               cfg_stage      - stage index, sampled on the last data beat
//               iop_vld/rdy/dat- input stream handshake and word
//               bpe_vld/rdy    - output pair handshake
//               bpe_a/b/c      - X[ia], X[ib], twiddle[tw_idx]
//               bpe_last       - final pair of the frame
//               err            - sticky: reserved beat or out-of-range stage
// Revision    : 1.0 - initial release
// ============================================================================
module bpe_stage_buf #(
    parameter int pDATA_WIDTH = 128,
    parameter int pLOG_N      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             in_sw,
    input  logic [3:0]             cfg_stage,
    input  logic                   iop_vld,
    output logic                   iop_rdy,
    input  logic [pDATA_WIDTH-1:0] iop_dat,
    output logic                   bpe_vld,
    input  logic                   bpe_rdy,
    output logic [pDATA_WIDTH-1:0] bpe_a,
    output logic [pDATA_WIDTH-1:0] bpe_b,
    output logic [pDATA_WIDTH-1:0] bpe_c,
    output logic                   bpe_last,
    output logic                   err
);

    localparam int c_N  = 1 << pLOG_N;
    localparam int c_H  = c_N / 2;
    localparam int c_AW = pLOG_N;
    localparam int c_TW = pLOG_N - 1;

    localparam logic [c_AW-1:0] c_ONE       = c_AW'(1);
    localparam logic [c_AW-1:0] c_WCNT_LAST = c_AW'(c_N - 1);
    localparam logic [c_TW-1:0] c_P_LAST    = c_TW'(c_H - 1);
    localparam logic [c_TW-1:0] c_TW_ONE    = c_TW'(1);
    localparam logic [3:0]      c_S_MAX     = 4'(pLOG_N - 1);

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Storage: plain register arrays, deliberately outside the reset domain.
    logic [pDATA_WIDTH-1:0] r_buf [c_N];
    logic [pDATA_WIDTH-1:0] r_tw  [c_H];

    state_t                 r_state_q, w_state_d;
    logic [c_AW-1:0]        r_wcnt_q,  w_wcnt_d;
    logic [c_TW-1:0]        r_tcnt_q,  w_tcnt_d;
    logic [c_TW-1:0]        r_p_q,     w_p_d;
    logic [3:0]             r_s_q,     w_s_d;
    logic                   r_err_q,   w_err_d;
    logic                   r_done_q,  w_done_d;   // every pair of the frame issued
    logic                   r_vld_q,   w_vld_d;
    logic                   r_last_q,  w_last_d;
    logic [pDATA_WIDTH-1:0] r_a_q,     w_a_d;
    logic [pDATA_WIDTH-1:0] r_b_q,     w_b_d;
    logic [pDATA_WIDTH-1:0] r_c_q,     w_c_d;

    logic            w_in_fire;
    logic            w_wr_dat;
    logic            w_wr_tw;
    logic            w_rsv;
    logic            w_stage_bad;
    logic            w_out_load;
    logic            w_out_accept;
    logic [3:0]      w_k;
    logic [c_AW-1:0] w_p_ext;
    logic [c_AW-1:0] w_mask;
    logic [c_AW-1:0] w_ia;
    logic [c_AW-1:0] w_ib;
    logic [c_TW-1:0] w_tw_idx;

    assign w_in_fire   = (r_state_q == ST_LOAD) && iop_vld;
    assign w_wr_dat    = w_in_fire && (in_sw == 2'b00);
    assign w_wr_tw     = w_in_fire && (in_sw == 2'b01);
    assign w_rsv       = w_in_fire && in_sw[1];
    assign w_stage_bad = ({28'd0, cfg_stage} >= 32'(pLOG_N));

    // Butterfly span h = 2^k with k = pLOG_N-1-s. ia is p with a zero
    // inserted at bit k, ib sets that bit, and the twiddle index is the
    // offset within the span scaled by 2^s.
    assign w_k      = c_S_MAX - r_s_q;
    assign w_p_ext  = {1'b0, r_p_q};
    assign w_mask   = (c_ONE << w_k) - c_ONE;
    assign w_ia     = ((w_p_ext & ~w_mask) << 1) | (w_p_ext & w_mask);
    assign w_ib     = w_ia | (c_ONE << w_k);
    assign w_tw_idx = c_TW'((w_p_ext & w_mask) << r_s_q);

    // The output register refills whenever it is empty or being drained.
    assign w_out_load   = (r_state_q == ST_DRAIN) && !r_done_q && (!r_vld_q || bpe_rdy);
    assign w_out_accept = r_vld_q && bpe_rdy;

    always_comb begin
        w_state_d = r_state_q;
        w_wcnt_d  = r_wcnt_q;
        w_tcnt_d  = r_tcnt_q;
        w_p_d     = r_p_q;
        w_s_d     = r_s_q;
        w_err_d   = r_err_q;
        w_done_d  = r_done_q;
        w_vld_d   = r_vld_q;
        w_last_d  = r_last_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_c_d     = r_c_q;

        if (w_wr_dat) begin
            w_wcnt_d = r_wcnt_q + c_ONE;
            if (r_wcnt_q == c_WCNT_LAST) begin
                w_wcnt_d  = '0;
                w_state_d = ST_DRAIN;
                w_s_d     = w_stage_bad ? c_S_MAX : cfg_stage;
                if (w_stage_bad) begin
                    w_err_d = 1'b1;
                end
            end
        end

        // Twiddle counter wraps naturally at N/2.
        if (w_wr_tw) begin
            w_tcnt_d = r_tcnt_q + c_TW_ONE;
        end

        if (w_rsv) begin
            w_err_d = 1'b1;
        end

        if (w_out_load) begin
            w_vld_d  = 1'b1;
            w_a_d    = r_buf[w_ia];
            w_b_d    = r_buf[w_ib];
            w_c_d    = r_tw[w_tw_idx];
            w_last_d = (r_p_q == c_P_LAST);
            w_done_d = (r_p_q == c_P_LAST);
            w_p_d    = r_p_q + c_TW_ONE;
        end else if (w_out_accept) begin
            w_vld_d = 1'b0;
        end

        // Handshake of the final pair returns the block to loading.
        if (w_out_accept && r_last_q) begin
            w_state_d = ST_LOAD;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_LOAD;
            r_wcnt_q  <= '0;
            r_tcnt_q  <= '0;
            r_p_q     <= '0;
            r_s_q     <= '0;
            r_err_q   <= 1'b0;
            r_done_q  <= 1'b0;
            r_vld_q   <= 1'b0;
            r_last_q  <= 1'b0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_c_q     <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wcnt_q  <= w_wcnt_d;
            r_tcnt_q  <= w_tcnt_d;
            r_p_q     <= w_p_d;
            r_s_q     <= w_s_d;
            r_err_q   <= w_err_d;
            r_done_q  <= w_done_d;
            r_vld_q   <= w_vld_d;
            r_last_q  <= w_last_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_c_q     <= w_c_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_dat) begin
            r_buf[r_wcnt_q] <= iop_dat;
        end
        if (!rst && w_wr_tw) begin
            r_tw[r_tcnt_q] <= iop_dat;
        end
    end

    assign iop_rdy  = (r_state_q == ST_LOAD);
    assign bpe_vld  = r_vld_q;
    assign bpe_a    = r_a_q;
    assign bpe_b    = r_b_q;
    assign bpe_c    = r_c_q;
    assign bpe_last = r_last_q;
    assign err      = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bpe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpe_stage_buf
// Description : Directed bench for bpe_stage_buf. An N=8 instance covers the
//               stage pairings, stalls, error cases, twiddle persistence and
//               reset mid-drain. A default-size instance covers the N=1024
//               case with ramp data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpe_stage_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=8 instance signals
    logic [1:0]   sw8;
    logic [3:0]   cfg8;
    logic         ivld8, irdy8, bvld8, brdy8, blast8, err8;
    logic [127:0] idat8, ba8, bb8, bc8;

    // N=1024 instance signals
    logic [1:0]   swk;
    logic [3:0]   cfgk;
    logic         ivldk, irdyk, bvldk, brdyk, blastk, errk;
    logic [127:0] idatk, bak, bbk, bck;

    bpe_stage_buf #(.pDATA_WIDTH(128), .pLOG_N(3)) u_dut8 (
        .clk(clk), .rst(rst), .in_sw(sw8), .cfg_stage(cfg8),
        .iop_vld(ivld8), .iop_rdy(irdy8), .iop_dat(idat8),
        .bpe_vld(bvld8), .bpe_rdy(brdy8), .bpe_a(ba8), .bpe_b(bb8),
        .bpe_c(bc8), .bpe_last(blast8), .err(err8)
    );

    bpe_stage_buf u_dutk (
        .clk(clk), .rst(rst), .in_sw(swk), .cfg_stage(cfgk),
        .iop_vld(ivldk), .iop_rdy(irdyk), .iop_dat(idatk),
        .bpe_vld(bvldk), .bpe_rdy(brdyk), .bpe_a(bak), .bpe_b(bbk),
        .bpe_c(bck), .bpe_last(blastk), .err(errk)
    );

    int n_checks = 0;
    int n_err    = 0;
    int ea [4];
    int eb [4];
    int et [4];

    function automatic logic [127:0] dv(input int i);
        return {64'hDA7A_0000_0000_0000, 64'(i)};
    endfunction

    function automatic logic [127:0] tv(input int i);
        return {64'h7F1D_0000_0000_0000, 64'(i)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input logic [1:0] sw, input logic [127:0] d, input logic [3:0] st);
        sw8   = sw;
        idat8 = d;
        cfg8  = st;
        ivld8 = 1'b1;
        tick();
        ivld8 = 1'b0;
    endtask

    task automatic load8(input logic [3:0] st, input int base);
        for (int i = 0; i < 8; i++) beat8(2'b00, dv(base + i), st);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Drains one N=8 frame against ea/eb/et; with stall, bpe_rdy cycles 1,0,0,1.
    // Values are compared on every valid cycle, so a stall must hold them.
    task automatic drain8(input bit stall, input int base, input string nm);
        int k;
        int cyc;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 64) begin
            brdy8 = stall ? pat[cyc % 4] : 1'b1;
            if (bvld8) begin
                chk($sformatf("%s_a%0d", nm, k), ba8, dv(base + ea[k]));
                chk($sformatf("%s_b%0d", nm, k), bb8, dv(base + eb[k]));
                chk($sformatf("%s_c%0d", nm, k), bc8, tv(et[k]));
                chk($sformatf("%s_last%0d", nm, k), 128'(blast8), 128'(k == 3));
                if (brdy8) k++;
            end
            tick();
            cyc++;
        end
        brdy8 = 1'b0;
        chk({nm, "_pairs"}, 128'(k), 128'(4));
        chk({nm, "_vld_end"}, 128'(bvld8), 128'(0));
        chk({nm, "_irdy_end"}, 128'(irdy8), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int badlast;

        rst = 1'b1;
        sw8 = 2'b00; cfg8 = 4'd0; ivld8 = 1'b0; idat8 = '0; brdy8 = 1'b0;
        swk = 2'b00; cfgk = 4'd4; ivldk = 1'b0; idatk = '0; brdyk = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // ---- reset state ----
        chk("rst_irdy", 128'(irdy8), 128'(1));
        chk("rst_vld", 128'(bvld8), 128'(0));
        chk("rst_a", ba8, 128'(0));
        chk("rst_b", bb8, 128'(0));
        chk("rst_c", bc8, 128'(0));
        chk("rst_last", 128'(blast8), 128'(0));
        chk("rst_err", 128'(err8), 128'(0));
        chk("rstk_irdy", 128'(irdyk), 128'(1));
        chk("rstk_vld", 128'(bvldk), 128'(0));

        // ---- stage 0 with twiddle load and latency ----
        for (int i = 0; i < 4; i++) beat8(2'b01, tv(i), 4'd0);
        load8(4'd0, 0);
        chk("lat_vld_c1", 128'(bvld8), 128'(0));
        chk("lat_irdy_c1", 128'(irdy8), 128'(0));
        tick();
        chk("lat_vld_c2", 128'(bvld8), 128'(1));
        ea = '{0, 1, 2, 3}; eb = '{4, 5, 6, 7}; et = '{0, 1, 2, 3};
        drain8(1'b0, 0, "s0");
        chk("s0_err", 128'(err8), 128'(0));

        // ---- stage 1, twiddles reused from the previous load ----
        load8(4'd1, 16);
        ea = '{0, 1, 4, 5}; eb = '{2, 3, 6, 7}; et = '{0, 2, 0, 2};
        drain8(1'b0, 16, "s1");

        // ---- stage 2 with stalls ----
        load8(4'd2, 32);
        ea = '{0, 2, 4, 6}; eb = '{1, 3, 5, 7}; et = '{0, 0, 0, 0};
        drain8(1'b1, 32, "s2st");

        // ---- out-of-range stage clamps to stage 2 ----
        pulse_rst();
        load8(4'd7, 48);
        chk("cfg7_err", 128'(err8), 128'(1));
        drain8(1'b0, 48, "cfg7");

        // ---- reserved beat mid-load: err set, write counter untouched ----
        pulse_rst();
        chk("rsv_err_before", 128'(err8), 128'(0));
        for (int i = 0; i < 4; i++) beat8(2'b00, dv(64 + i), 4'd0);
        beat8(2'b10, 128'hBAD0_BAD0, 4'd0);
        chk("rsv_err", 128'(err8), 128'(1));
        chk("rsv_irdy", 128'(irdy8), 128'(1));
        for (int i = 4; i < 8; i++) beat8(2'b00, dv(64 + i), 4'd0);
        ea = '{0, 1, 2, 3}; eb = '{4, 5, 6, 7}; et = '{0, 1, 2, 3};
        drain8(1'b0, 64, "rsv");

        // ---- reset mid-drain, then a fresh frame from p=0 ----
        pulse_rst();
        load8(4'd7, 80);
        brdy8 = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_vld_pre", 128'(bvld8), 128'(1));
        chk("mid_a2_pre", ba8, dv(84));
        rst = 1'b1;
        tick();
        chk("mid_rst_vld", 128'(bvld8), 128'(0));
        chk("mid_rst_irdy", 128'(irdy8), 128'(1));
        chk("mid_rst_err", 128'(err8), 128'(0));
        rst   = 1'b0;
        brdy8 = 1'b0;
        load8(4'd0, 96);
        ea = '{0, 1, 2, 3}; eb = '{4, 5, 6, 7}; et = '{0, 1, 2, 3};
        drain8(1'b0, 96, "fresh");

        // ---- default size: N=1024, stage 4, ramp data ----
        for (int i = 0; i < 512; i++) begin
            swk = 2'b01; idatk = tv(i); ivldk = 1'b1;
            tick();
        end
        for (int i = 0; i < 1024; i++) begin
            swk = 2'b00; idatk = 128'(i); cfgk = 4'd4; ivldk = 1'b1;
            tick();
        end
        ivldk   = 1'b0;
        brdyk   = 1'b1;
        k       = 0;
        badlast = 0;
        for (int cyc = 0; cyc < 2000 && k < 512; cyc++) begin
            if (bvldk) begin
                if (k == 0) begin
                    chk("n1k_p0_a", bak, 128'(0));
                    chk("n1k_p0_b", bbk, 128'(32));
                end
                if (k == 5) chk("n1k_p5_c", bck, tv(80));
                if (k == 32) begin
                    chk("n1k_p32_a", bak, 128'(64));
                    chk("n1k_p32_b", bbk, 128'(96));
                end
                if (k == 511) chk("n1k_last511", 128'(blastk), 128'(1));
                if (blastk != (k == 511)) badlast++;
                k++;
            end
            tick();
        end
        brdyk = 1'b0;
        chk("n1k_pairs", 128'(k), 128'(512));
        chk("n1k_badlast", 128'(badlast), 128'(0));
        chk("n1k_vld_end", 128'(bvldk), 128'(0));
        chk("n1k_irdy_end", 128'(irdyk), 128'(1));
        chk("n1k_err", 128'(errk), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
